key_inv_expansion: RTL and testbench
====================================

Name: key_inv_expansion

Overview:
- Inverse AES-128 key schedule: reads the round-N key from the key-store SRAM, computes the round-(N-1) key and writes it back in place.
- Used by the decryption path to walk round keys backwards, from round 10 down to round 0.
- Drives the same single-port SRAM request interface that the forward key expansion uses. The key is 128 bits, with word w0 in bits [31:0] and w3 in bits [127:96].

Parameters:
- ADDR_W, 16, SRAM address width.
- KEY_ADDR, 16, SRAM address of the working round key; the same address is used for both read and write.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- enable  in  1  start pulse; sampled only in IDLE.
- round_num  in  4  round index N of the key currently stored in SRAM; valid range 1..10.
- sram_read_value  in  128  SRAM read data; valid the cycle after sram_read=1 and held until the next read.
- sram_read  out  1  SRAM read strobe.
- sram_write  out  1  SRAM write strobe.
- sram_addr  out  ADDR_W  SRAM address.
- sram_write_value  out  128  SRAM write data.
- done  out  1  one-cycle completion pulse.
- err  out  1  qualifies done: the round number was illegal and no SRAM access occurred.

Behaviour:
- Reset: synchronous. On a clk edge with rst=1, state goes to IDLE and every output, key register, word register and byte counter is cleared to 0.
  - Reset mid-operation aborts with no write. The write only happens in state WR, so the SRAM never holds a partial key.
- Outputs are Moore-decoded from state.
  - sram_addr=KEY_ADDR in RD_REQ and WR; 0 elsewhere.
  - sram_write_value equals the assembled key in WR only; 0 elsewhere.
- Word math. Let n0..n3 be the words of the read key and o0..o3 the words of the previous key.
  - o3=n3^n2
  - o2=n2^n1
  - o1=n1^n0
  - o0=n0^g(o3)
  - g(w)=SubWord(RotWord(w)) ^ {RCON[N],24'h0}
  - RotWord(w)={w[23:0],w[31:24]}
  - RCON[1..10]=01,02,04,08,10,20,40,80,1B,36
- FSM:
  - IDLE: enable=1 with round_num in 1..10 -> RD_REQ. enable=1 with round_num=0 or >10 -> DONE with err latched to 1. Otherwise stay in IDLE.
  - RD_REQ: sram_read=1 for one cycle -> RD_CAP.
  - RD_CAP: capture sram_read_value into the key register; latch the RCON byte from round_num -> X3.
  - X3: compute o3 -> X2.
  - X2: compute o2 -> X1.
  - X1: compute o1 -> SUB, with byte counter=0.
  - SUB: one S-box lookup per cycle on byte[counter] of RotWord(o3), result stored into the temp word. After counter=3 -> X0. This state lasts exactly 4 cycles.
  - X0: o0=n0 ^ temp ^ RCON -> WR.
  - WR: sram_write=1 for one cycle with data {o3,o2,o1,o0} -> DONE.
  - DONE: done=1 for one cycle, err as latched -> IDLE; err is cleared on leaving DONE.
- Latency:
  - Valid request: done rises 12 cycles after the edge that samples enable. sram_read is high in cycle 1 and sram_write in cycle 11.
  - Error request: done rises 1 cycle after the sampling edge.
- Handshake and input rules:
  - enable is ignored outside IDLE.
  - round_num is sampled only in IDLE and RD_CAP; later changes have no effect.
  - enable held high continuously re-triggers one operation per return to IDLE, with no gap beyond the IDLE cycle.
- Boundary cases:
  - N=10 uses RCON 36; N=1 produces the cipher key.
  - sram_read and sram_write are never high in the same cycle.

Decomposition:
- Package aes_key_pkg holds:
  - the RCON table (function or array indexed 1..10);
  - the FSM state enum typedef;
  - the KEY_ADDR default;
  - the word-slice helper functions (word select, RotWord).
- Sub-module aes_sbox: combinational 8-bit forward S-box LUT, instantiated once and time-shared across the 4 SUB cycles.

Test Plan:
- FIPS-197 A.1 round 10 -> 9: SRAM[16]={b6630ca6,e13f0cc8,c9ee2589,d014f9a8}, round_num=10. Required: write data {575c006e,28d12941,19fadc21,ac7766f3}, done at cycle 12, err=0.
- Round 1 -> 0: SRAM[16]={2a6c7605,23a33939,88542cb1,a0fafe17}, round_num=1. Required: write data {09cf4f3c,abf71588,28aed2a6,2b7e1516}.
- Full walk back: start from the round-10 key and run 10 times with round_num=10..1. Required: final SRAM[16] equals the cipher key 2b7e1516.. and every intermediate key matches the forward-expansion output.
- Illegal round: round_num=0, then 11. Required: done and err high one cycle after enable, with sram_read and sram_write never asserted.
- Reset mid-op: assert rst during SUB. Required: next cycle is IDLE with all outputs 0, sram_write never pulses, and SRAM[16] is unchanged.
- Busy enable: pulse enable again during X2 with round_num changed. Required: exactly one write with the original result and one done pulse.

Source files
------------

// File: rtl/aes_key_pkg.sv
// Shared types and helpers for the AES-128 key schedule blocks.
// Holds the round-constant table, FSM state encoding and 32-bit word utilities.
package aes_key_pkg;

    localparam int unsigned KEY_ADDR_DEF = 16;
    localparam int unsigned KEY_W        = 128;
    localparam int unsigned WORD_W       = 32;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_RD_REQ = 4'd1,
        ST_RD_CAP = 4'd2,
        ST_X3     = 4'd3,
        ST_X2     = 4'd4,
        ST_X1     = 4'd5,
        ST_SUB    = 4'd6,
        ST_X0     = 4'd7,
        ST_WR     = 4'd8,
        ST_DONE   = 4'd9
    } state_t;

    // Round constant for rounds 1..10; zero for anything else.
    function automatic logic [7:0] rcon(input logic [3:0] n);
        case (n)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [WORD_W-1:0] word_sel(input logic [KEY_W-1:0] k, input logic [1:0] idx);
        return k[{idx, 5'b00000} +: WORD_W];
    endfunction

    function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/key_inv_expansion_if.sv
// Start/completion handshake plus single-port key-store SRAM request bus.
interface key_inv_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              enable;
    logic [3:0]        round_num;
    logic [127:0]      sram_read_value;
    logic              sram_read;
    logic              sram_write;
    logic [ADDR_W-1:0] sram_addr;
    logic [127:0]      sram_write_value;
    logic              done;
    logic              err;

    // The key engine drives the SRAM requests and reports completion.
    modport master (
        input  enable, round_num, sram_read_value,
        output sram_read, sram_write, sram_addr, sram_write_value, done, err
    );

    modport slave (
        output enable, round_num, sram_read_value,
        input  sram_read, sram_write, sram_addr, sram_write_value, done, err
    );
endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    // Entry 0 sits in the top byte, so the lookup offset is (255 - a) * 8.
    localparam logic [2047:0] SBOX_FLAT = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y_o = SBOX_FLAT[{~a_i, 3'b000} +: 8];
endmodule

// File: rtl/key_inv_expansion.sv
// Inverse AES-128 key schedule: reads round-N key from SRAM, writes round-(N-1) key in place.
// One shared S-box is walked over the four bytes of RotWord(o3).
module key_inv_expansion
    import aes_key_pkg::*;
#(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned KEY_ADDR = KEY_ADDR_DEF
) (
    input  logic      clk,
    input  logic      rst,
    key_inv_if.master bus
);
    state_t              state_q, state_d;
    logic [KEY_W-1:0]    key_q,   key_d;
    logic [WORD_W-1:0]   temp_q,  temp_d;
    logic [7:0]          rcon_q,  rcon_d;
    logic [1:0]          cnt_q,   cnt_d;
    logic                err_q,   err_d;

    logic [WORD_W-1:0]   rot_o3;
    logic [7:0]          sbox_in;
    logic [7:0]          sbox_out;
    logic                round_ok;

    assign rot_o3   = rot_word(word_sel(key_q, 2'd3));
    assign sbox_in  = rot_o3[{cnt_q, 3'b000} +: 8];
    assign round_ok = (bus.round_num >= 4'd1) && (bus.round_num <= 4'd10);

    aes_sbox u_sbox (
        .a_i (sbox_in),
        .y_o (sbox_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            temp_q  <= '0;
            rcon_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            temp_q  <= temp_d;
            rcon_q  <= rcon_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Words are updated in place high-to-low so each step still sees the unmodified lower word.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        temp_d  = temp_q;
        rcon_d  = rcon_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.enable) begin
                    if (round_ok) begin
                        state_d = ST_RD_REQ;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RD_REQ: state_d = ST_RD_CAP;
            ST_RD_CAP: begin
                key_d   = bus.sram_read_value;
                rcon_d  = rcon(bus.round_num);
                state_d = ST_X3;
            end
            ST_X3: begin
                key_d[127:96] = key_q[127:96] ^ key_q[95:64];
                state_d       = ST_X2;
            end
            ST_X2: begin
                key_d[95:64] = key_q[95:64] ^ key_q[63:32];
                state_d      = ST_X1;
            end
            ST_X1: begin
                key_d[63:32] = key_q[63:32] ^ key_q[31:0];
                cnt_d        = 2'd0;
                state_d      = ST_SUB;
            end
            ST_SUB: begin
                temp_d[{cnt_q, 3'b000} +: 8] = sbox_out;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = ST_X0;
                end
            end
            ST_X0: begin
                key_d[31:0] = key_q[31:0] ^ temp_q ^ {rcon_q, 24'h000000};
                state_d     = ST_WR;
            end
            ST_WR: state_d = ST_DONE;
            ST_DONE: begin
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from the state register.
    assign bus.sram_read        = (state_q == ST_RD_REQ);
    assign bus.sram_write       = (state_q == ST_WR);
    assign bus.sram_addr        = ((state_q == ST_RD_REQ) || (state_q == ST_WR)) ? ADDR_W'(KEY_ADDR) : '0;
    assign bus.sram_write_value = (state_q == ST_WR) ? key_q : '0;
    assign bus.done             = (state_q == ST_DONE);
    assign bus.err              = (state_q == ST_DONE) && err_q;

endmodule

// File: tb/tb_key_inv_expansion.sv
// Bench for key_inv_expansion: vector table, scoreboarded SRAM writes and corner sequences.
module tb_key_inv_expansion;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned KADDR  = 16;
    localparam logic [127:0] CIPHER = 128'h09cf4f3c_abf71588_28aed2a6_2b7e1516;

    localparam logic [2047:0] TB_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    key_inv_if #(.ADDR_W(ADDR_W)) bus ();

    key_inv_expansion #(.ADDR_W(ADDR_W), .KEY_ADDR(KADDR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // Key-store SRAM: only the working-key location is modelled.
    logic [127:0] mem;
    always @(posedge clk) begin
        if (bus.sram_write && bus.sram_addr == ADDR_W'(KADDR)) mem <= bus.sram_write_value;
        if (bus.sram_read) bus.sram_read_value <= (bus.sram_addr == ADDR_W'(KADDR)) ? mem : '0;
    end

    int n_vec = 0;
    int n_err = 0;
    int n_wr = 0;
    int n_done = 0;
    logic [127:0] exp_wr_q[$];
    bit           exp_done_q[$];
    logic [127:0] rk[0:10];
    logic [7:0]   tb_rcon[1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] tb_subword(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = TB_SBOX[(255 - int'(w[i*8 +: 8])) * 8 +: 8];
        return r;
    endfunction

    // Forward expansion from the cipher key gives every round key.
    task automatic build_round_keys();
        logic [31:0] t, w0, w1, w2, w3, p3;
        rk[0] = CIPHER;
        for (int r = 1; r <= 10; r++) begin
            p3 = rk[r-1][127:96];
            t  = tb_subword({p3[23:0], p3[31:24]}) ^ {tb_rcon[r], 24'h000000};
            w0 = rk[r-1][31:0]   ^ t;
            w1 = rk[r-1][63:32]  ^ w0;
            w2 = rk[r-1][95:64]  ^ w1;
            w3 = rk[r-1][127:96] ^ w2;
            rk[r] = {w3, w2, w1, w0};
        end
    endtask

    // Scoreboard: pops expected write data and done/err on each DUT event.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            check("rd_wr_overlap", 128'(bus.sram_read & bus.sram_write), 128'(0));
            if (bus.sram_write) begin
                n_wr++;
                check("write_expected", 128'(exp_wr_q.size() != 0), 128'(1));
                if (exp_wr_q.size() != 0) begin
                    check("write_data", bus.sram_write_value, exp_wr_q.pop_front());
                    check("write_addr", 128'(bus.sram_addr), 128'(KADDR));
                end
            end
            if (bus.done) begin
                n_done++;
                check("done_expected", 128'(exp_done_q.size() != 0), 128'(1));
                if (exp_done_q.size() != 0) check("done_err", 128'(bus.err), 128'(exp_done_q.pop_front()));
            end
        end
    end

    task automatic run_op(input logic [3:0] rn, input logic [127:0] exp_key, input bit is_err, input string tag);
        int rd_c = 0, wr_c = 0, dn_c = 0;
        if (!is_err) exp_wr_q.push_back(exp_key);
        exp_done_q.push_back(is_err);
        @(negedge clk);
        bus.enable    = 1'b1;
        bus.round_num = rn;
        @(posedge clk);
        for (int i = 1; i <= 20 && dn_c == 0; i++) begin
            @(negedge clk);
            bus.enable = 1'b0;
            if (bus.sram_read  && rd_c == 0) rd_c = i;
            if (bus.sram_write && wr_c == 0) wr_c = i;
            if (bus.done) dn_c = i;
        end
        check({tag, "_done_cycle"},  128'(dn_c), is_err ? 128'(1) : 128'(12));
        check({tag, "_read_cycle"},  128'(rd_c), is_err ? 128'(0) : 128'(1));
        check({tag, "_write_cycle"}, 128'(wr_c), is_err ? 128'(0) : 128'(11));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_sram_read"},  128'(bus.sram_read),  128'(0));
        check({tag, "_sram_write"}, 128'(bus.sram_write), 128'(0));
        check({tag, "_sram_addr"},  128'(bus.sram_addr),  128'(0));
        check({tag, "_wdata"},      bus.sram_write_value, 128'(0));
        check({tag, "_done"},       128'(bus.done),       128'(0));
        check({tag, "_err"},        128'(bus.err),        128'(0));
    endtask

    typedef struct {
        logic [3:0]   rn;
        logic [127:0] init;
        logic [127:0] exp_key;
        bit           err;
        string        name;
    } vec_t;

    vec_t vt[6];

    initial begin
        int w0, d0;
        mem           = '0;
        rst           = 1'b1;
        bus.enable    = 1'b0;
        bus.round_num = 4'd0;
        build_round_keys();

        vt[0] = '{4'd10, 128'hb6630ca6_e13f0cc8_c9ee2589_d014f9a8,
                  128'h575c006e_28d12941_19fadc21_ac7766f3, 1'b0, "fips_r10"};
        vt[1] = '{4'd1,  128'h2a6c7605_23a33939_88542cb1_a0fafe17, CIPHER, 1'b0, "fips_r1"};
        vt[2] = '{4'd5,  rk[5], rk[4], 1'b0, "model_r5"};
        vt[3] = '{4'd0,  rk[2], rk[2], 1'b1, "illegal_r0"};
        vt[4] = '{4'd11, rk[2], rk[2], 1'b1, "illegal_r11"};
        vt[5] = '{4'd15, rk[4], rk[4], 1'b1, "illegal_r15"};

        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        foreach (vt[k]) begin
            @(negedge clk);
            mem = vt[k].init;
            run_op(vt[k].rn, vt[k].exp_key, vt[k].err, vt[k].name);
            check({vt[k].name, "_sram"}, mem, vt[k].exp_key);
        end

        // Walk back from round 10 to the cipher key.
        @(negedge clk);
        mem = rk[10];
        for (int n = 10; n >= 1; n--) begin
            run_op(4'(n), rk[n-1], 1'b0, $sformatf("walk_r%0d", n));
            check($sformatf("walk_key_r%0d", n - 1), mem, rk[n-1]);
        end
        check("walk_cipher_key", mem, CIPHER);

        // Reset during SUB: no write, SRAM untouched, outputs cleared.
        @(negedge clk);
        mem = rk[3];
        w0 = n_wr;
        bus.enable    = 1'b1;
        bus.round_num = 4'd3;
        @(posedge clk);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            bus.enable = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("midreset");
        rst = 1'b0;
        repeat (16) @(negedge clk);
        check("midreset_sram", mem, rk[3]);
        check("midreset_no_write", 128'(n_wr - w0), 128'(0));

        // Enable pulsed again during X2 with a different round: ignored.
        w0 = n_wr;
        d0 = n_done;
        mem = rk[7];
        exp_wr_q.push_back(rk[6]);
        exp_done_q.push_back(1'b0);
        @(negedge clk);
        bus.enable    = 1'b1;
        bus.round_num = 4'd7;
        @(posedge clk);
        begin
            int dn_c = 0;
            for (int i = 1; i <= 20 && dn_c == 0; i++) begin
                @(negedge clk);
                bus.enable = (i == 4);
                if (i == 4) bus.round_num = 4'd2;
                if (bus.done) dn_c = i;
            end
            bus.enable = 1'b0;
            check("busy_done_cycle", 128'(dn_c), 128'(12));
        end
        repeat (4) @(negedge clk);
        check("busy_sram", mem, rk[6]);
        check("busy_one_write", 128'(n_wr - w0), 128'(1));
        check("busy_one_done", 128'(n_done - d0), 128'(1));

        check("wr_queue_drained", 128'(exp_wr_q.size()), 128'(0));
        check("done_queue_drained", 128'(exp_done_q.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
